// File: rtl/oldland_mem_access_if.sv
// Data-bus signals between the memory-access stage (master) and the data
// memory or bus fabric (slave).
interface oldland_mem_access_if;
    logic [31:0] d_addr;
    logic [3:0]  d_bytesel;
    logic        d_wr_en;
    logic        d_access;
    logic [31:0] d_wr_val;
    logic [31:0] d_data;
    logic        d_ack;

    modport master (
        output d_addr, d_bytesel, d_wr_en, d_access, d_wr_val,
        input  d_data, d_ack
    );

    modport slave (
        input  d_addr, d_bytesel, d_wr_en, d_access, d_wr_val,
        output d_data, d_ack
    );
endinterface

// File: rtl/oldland_mem_access.sv
// Memory-access pipeline stage: issues one data-bus transaction per load/store,
// steers byte lanes, formats load data and produces the writeback record.
//
//   state | meaning
//   IDLE  | accept next instruction; pass through non-memory results
//   BUSY  | bus request outstanding, waiting for d_ack or timeout
module oldland_mem_access #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 addr,
    input  logic [31:0]                 wr_val,
    input  logic                        mem_load,
    input  logic                        mem_store,
    input  logic [1:0]                  mem_width,
    input  logic                        wr_result,
    input  logic [2:0]                  rd_sel,
    oldland_mem_access_if.master        bus,
    output logic                        busy,
    output logic [31:0]                 wb_val,
    output logic                        wb_update,
    output logic [2:0]                  wb_rd_sel,
    output logic                        data_abort
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [31:0] count;
    logic [1:0]  lat_width;
    logic [1:0]  lat_off;
    logic        lat_store;
    logic [2:0]  lat_rd;

    logic        access;
    logic        misaligned;
    logic        timeout_now;
    logic [3:0]  lanes;
    logic [31:0] store_data;
    logic [31:0] lane_shift;
    logic [31:0] load_data;

    assign access      = mem_load | mem_store;
    assign timeout_now = (ACK_TIMEOUT != 0) && (count == TIMEOUT_LAST);

    // Reserved width 11 falls through to the word defaults.
    always_comb begin
        lanes      = 4'b1111;
        misaligned = |addr[1:0];
        store_data = wr_val;
        case (mem_width)
            2'b01: begin
                lanes      = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
                store_data = {2{wr_val[15:0]}};
            end
            2'b10: begin
                lanes      = 4'b0001 << addr[1:0];
                misaligned = 1'b0;
                store_data = {4{wr_val[7:0]}};
            end
            default: begin
            end
        endcase
    end

    // Latched offset is zero for words and lane-aligned for halves.
    always_comb begin
        lane_shift = bus.d_data >> {lat_off, 3'b000};
        case (lat_width)
            2'b01:   load_data = {16'h0000, lane_shift[15:0]};
            2'b10:   load_data = {24'h000000, lane_shift[7:0]};
            default: load_data = lane_shift;
        endcase
    end

    always_comb begin
        if (state == IDLE) busy = access & ~misaligned;
        else               busy = ~bus.d_ack & ~timeout_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            lat_width     <= '0;
            lat_off       <= '0;
            lat_store     <= 1'b0;
            lat_rd        <= '0;
            bus.d_addr    <= '0;
            bus.d_bytesel <= '0;
            bus.d_wr_en   <= 1'b0;
            bus.d_access  <= 1'b0;
            bus.d_wr_val  <= '0;
            wb_val        <= '0;
            wb_update     <= 1'b0;
            wb_rd_sel     <= '0;
            data_abort    <= 1'b0;
        end else begin
            wb_update  <= 1'b0;
            data_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (!access) begin
                        wb_val    <= wr_val;
                        wb_update <= wr_result;
                        wb_rd_sel <= rd_sel;
                    end else if (misaligned) begin
                        data_abort <= 1'b1;
                    end else begin
                        bus.d_addr    <= {addr[31:2], 2'b00};
                        bus.d_bytesel <= lanes;
                        bus.d_wr_en   <= mem_store;
                        bus.d_wr_val  <= store_data;
                        bus.d_access  <= 1'b1;
                        count         <= '0;
                        lat_width     <= mem_width;
                        lat_off       <= addr[1:0];
                        lat_store     <= mem_store;
                        lat_rd        <= rd_sel;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.d_ack) begin
                        bus.d_access <= 1'b0;
                        state        <= IDLE;
                        if (!lat_store) begin
                            wb_update <= 1'b1;
                            wb_rd_sel <= lat_rd;
                            wb_val    <= load_data;
                        end
                    end else if (timeout_now) begin
                        bus.d_access <= 1'b0;
                        data_abort   <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
